// File: rtl/core_pkg.sv
// core_pkg
// Shared definitions for the 5-stage core's ID/EX boundary logic.
// Both the hazard controller and the forwarding unit import this package.
//   REG_ADDR_W       - width of a register-file address
//   ZERO_REG         - address of the architectural zero register
//   hazard_state_t   - memory-wait sequencing states of the hazard controller
//   reg_match        - "does this source read the register that dest writes"
package core_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } hazard_state_t;

  // A source depends on a destination only if it is really read and the
  // addresses agree. With a hard-wired zero register, writes to r0 are
  // discarded, so r0 can never carry a dependency.
  function automatic logic reg_match(
    input logic                  use_src,
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] dest,
    input logic                  zero_hardwired
  );
    reg_match = use_src && (src == dest) &&
                !(zero_hardwired && (dest == ZERO_REG));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Event counter that stops at all-ones instead of wrapping, so a long run
// never makes the count look small.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset, clears the count
//   inc    in  count one event on this edge
//   count  out current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller
// Pipeline sequencing for the 5-stage core. Each cycle it picks one action:
// freeze everything while memory is busy, flush on a taken branch, or stall
// IF/ID and insert an EX bubble on a data hazard. A watchdog FSM turns an
// over-long memory wait into a sticky error, and two saturating counters
// record stall cycles and branch flushes.
//   clk, rst_n                 clock / async active-low reset
//   forward_en                 forwarding unit enabled (only load-use stalls)
//   ID_src1/2, ID_use_src1/2   sources of the instruction in ID
//   EX_dest, EX_regWrite, EX_memRead   instruction in EX
//   MEM_dest, MEM_regWrite, MEM_memAccess   instruction in MEM
//   mem_ready                  memory completes this cycle
//   branch_taken               EX resolved a taken branch
//   freeze                     hold every pipeline register and the PC
//   stall_fetch                hold PC and IF/ID
//   bubble_ex                  load NOP into ID/EX
//   flush_if_id                clear IF/ID
//   mem_err                    sticky memory-timeout error
//   stall_cnt, flush_cnt       saturating performance counters
module hazard_controller
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT        = 64,
  parameter int CNT_W              = 32,
  parameter int ZERO_REG_HARDWIRED = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  forward_en,
  input  logic [REG_ADDR_W-1:0] ID_src1,
  input  logic [REG_ADDR_W-1:0] ID_src2,
  input  logic                  ID_use_src1,
  input  logic                  ID_use_src2,
  input  logic [REG_ADDR_W-1:0] EX_dest,
  input  logic                  EX_regWrite,
  input  logic                  EX_memRead,
  input  logic [REG_ADDR_W-1:0] MEM_dest,
  input  logic                  MEM_regWrite,
  input  logic                  MEM_memAccess,
  input  logic                  mem_ready,
  input  logic                  branch_taken,
  output logic                  freeze,
  output logic                  stall_fetch,
  output logic                  bubble_ex,
  output logic                  flush_if_id,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // Wide enough to hold MEM_TIMEOUT-1 with headroom.
  localparam int WCNT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(MEM_TIMEOUT - 1);
  localparam logic ZERO_HW = (ZERO_REG_HARDWIRED != 0);

  hazard_state_t     state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic mem_busy;
  logic ex_match;
  logic mem_match;
  logic haz;

  assign mem_busy = MEM_memAccess && !mem_ready;

  assign ex_match  = reg_match(ID_use_src1, ID_src1, EX_dest, ZERO_HW) ||
                     reg_match(ID_use_src2, ID_src2, EX_dest, ZERO_HW);
  assign mem_match = reg_match(ID_use_src1, ID_src1, MEM_dest, ZERO_HW) ||
                     reg_match(ID_use_src2, ID_src2, MEM_dest, ZERO_HW);

  // With forwarding only a load in EX cannot be bypassed in time; without
  // it, any in-flight writer in EX or MEM must retire first.
  always_comb begin
    if (forward_en) begin
      haz = EX_memRead && EX_regWrite && ex_match;
    end else begin
      haz = (EX_regWrite && ex_match) || (MEM_regWrite && mem_match);
    end
  end

  // Control outputs. A busy memory freezes everything, which also holds the
  // branch and hazard sources in place, so those are simply acted on once
  // the freeze lifts. A taken branch makes the ID instruction wrong-path,
  // so any hazard it raises is ignored. Outputs are forced low while reset
  // is asserted so a reset mid-wait releases the pipeline at once.
  always_comb begin
    freeze      = 1'b0;
    stall_fetch = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    if (rst_n) begin
      if (state_q == ERR) begin
        freeze = 1'b1;
      end else if (mem_busy) begin
        freeze = 1'b1;
      end else if (branch_taken) begin
        flush_if_id = 1'b1;
        bubble_ex   = 1'b1;
      end else if (haz) begin
        stall_fetch = 1'b1;
        bubble_ex   = 1'b1;
      end
    end
  end

  // Memory-wait watchdog. wait_cnt counts busy cycles seen so far, the one
  // that left RUN included, so ERR is reached at the edge closing the
  // MEM_TIMEOUT-th consecutive busy cycle.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d    = WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      WAIT: begin
        if (!mem_busy) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q >= WAIT_LIMIT) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign mem_err = (state_q == ERR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (freeze || stall_fetch),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_if_id),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller
// Self-checking bench for hazard_controller with MEM_TIMEOUT=4, CNT_W=4.
// Inputs change 1 time unit after a rising edge, outputs are sampled on the
// falling edge. A behavioural reference model predicts each cycle's
// outputs; expectations are queued when stimulus is driven and popped when
// the outputs are sampled.
module tb_hazard_controller;

  localparam int MT = 4;
  localparam int CW = 4;
  localparam int CMAX = 15;

  localparam int M_RUN  = 0;
  localparam int M_WAIT = 1;
  localparam int M_ERR  = 2;

  typedef struct packed {
    logic       fwd;
    logic [4:0] s1;
    logic [4:0] s2;
    logic       u1;
    logic       u2;
    logic [4:0] exd;
    logic       exw;
    logic       exr;
    logic [4:0] md;
    logic       mw;
    logic       ma;
    logic       rdy;
    logic       br;
  } in_t;

  // ctrl bit order: {freeze, stall_fetch, bubble_ex, flush_if_id}
  typedef struct packed {
    in_t        in;
    logic [3:0] ctrl;
  } vec_t;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       err;
    logic [3:0] scnt;
    logic [3:0] fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic forward_en = 1'b0;
  logic [4:0] ID_src1 = '0, ID_src2 = '0, EX_dest = '0, MEM_dest = '0;
  logic ID_use_src1 = 1'b0, ID_use_src2 = 1'b0;
  logic EX_regWrite = 1'b0, EX_memRead = 1'b0, MEM_regWrite = 1'b0;
  logic MEM_memAccess = 1'b0, mem_ready = 1'b0, branch_taken = 1'b0;
  logic freeze, stall_fetch, bubble_ex, flush_if_id, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_miss = 0;

  int m_state = M_RUN;
  int m_wait = 0;
  int m_scnt = 0;
  int m_fcnt = 0;

  exp_t exp_q[$];
  vec_t tab[12];

  hazard_controller #(
    .MEM_TIMEOUT        (MT),
    .CNT_W              (CW),
    .ZERO_REG_HARDWIRED (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .forward_en    (forward_en),
    .ID_src1       (ID_src1),
    .ID_src2       (ID_src2),
    .ID_use_src1   (ID_use_src1),
    .ID_use_src2   (ID_use_src2),
    .EX_dest       (EX_dest),
    .EX_regWrite   (EX_regWrite),
    .EX_memRead    (EX_memRead),
    .MEM_dest      (MEM_dest),
    .MEM_regWrite  (MEM_regWrite),
    .MEM_memAccess (MEM_memAccess),
    .mem_ready     (mem_ready),
    .branch_taken  (branch_taken),
    .freeze        (freeze),
    .stall_fetch   (stall_fetch),
    .bubble_ex     (bubble_ex),
    .flush_if_id   (flush_if_id),
    .mem_err       (mem_err),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic in_t idle_in();
    in_t v;
    v = '0;
    return v;
  endfunction

  function automatic logic m_match(input logic u, input logic [4:0] s, input logic [4:0] d);
    return u && (s == d) && (d != 5'd0);
  endfunction

  // Reference: decision priority ERR > memory busy > branch > hazard.
  function automatic logic [3:0] model_ctrl(input in_t v);
    logic busy, exm, mm, hz;
    busy = v.ma && !v.rdy;
    exm  = m_match(v.u1, v.s1, v.exd) || m_match(v.u2, v.s2, v.exd);
    mm   = m_match(v.u1, v.s1, v.md) || m_match(v.u2, v.s2, v.md);
    if (v.fwd) hz = v.exr && v.exw && exm;
    else       hz = (v.exw && exm) || (v.mw && mm);
    if (m_state == M_ERR) return 4'b1000;
    if (busy)             return 4'b1000;
    if (v.br)             return 4'b0011;
    if (hz)               return 4'b0110;
    return 4'b0000;
  endfunction

  task automatic model_step(input in_t v);
    logic [3:0] c;
    logic busy;
    c = model_ctrl(v);
    busy = v.ma && !v.rdy;
    if ((c[3] || c[2]) && m_scnt < CMAX) m_scnt++;
    if (c[0] && m_fcnt < CMAX) m_fcnt++;
    case (m_state)
      M_RUN:  if (busy) begin m_state = M_WAIT; m_wait = 1; end
      M_WAIT: begin
        if (!busy) begin m_state = M_RUN; m_wait = 0; end
        else if (m_wait == MT - 1) m_state = M_ERR;
        else m_wait++;
      end
      default: m_state = M_ERR;
    endcase
  endtask

  task automatic model_reset();
    m_state = M_RUN;
    m_wait = 0;
    m_scnt = 0;
    m_fcnt = 0;
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t v);
    forward_en    = v.fwd;
    ID_src1       = v.s1;
    ID_src2       = v.s2;
    ID_use_src1   = v.u1;
    ID_use_src2   = v.u2;
    EX_dest       = v.exd;
    EX_regWrite   = v.exw;
    EX_memRead    = v.exr;
    MEM_dest      = v.md;
    MEM_regWrite  = v.mw;
    MEM_memAccess = v.ma;
    mem_ready     = v.rdy;
    branch_taken  = v.br;
  endtask

  // Drive one cycle of stimulus and queue what the outputs must be. When a
  // table expectation is supplied it is used for the control bits.
  task automatic applyStimulus(input in_t v, input logic use_tab, input logic [3:0] tab_ctrl);
    exp_t e;
    drive(v);
    e.ctrl = use_tab ? tab_ctrl : model_ctrl(v);
    e.err  = (m_state == M_ERR);
    e.scnt = 4'(m_scnt);
    e.fcnt = 4'(m_fcnt);
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      cmp({tag, "_queue_empty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    cmp({tag, "_freeze"},      int'(freeze),      int'(e.ctrl[3]));
    cmp({tag, "_stall_fetch"}, int'(stall_fetch), int'(e.ctrl[2]));
    cmp({tag, "_bubble_ex"},   int'(bubble_ex),   int'(e.ctrl[1]));
    cmp({tag, "_flush_if_id"}, int'(flush_if_id), int'(e.ctrl[0]));
    cmp({tag, "_mem_err"},     int'(mem_err),     int'(e.err));
    cmp({tag, "_stall_cnt"},   int'(stall_cnt),   int'(e.scnt));
    cmp({tag, "_flush_cnt"},   int'(flush_cnt),   int'(e.fcnt));
  endtask

  // One full cycle: drive after an edge, sample at the falling edge, then
  // advance the model across the next rising edge.
  task automatic run_cycle(input string tag, input in_t v, input logic use_tab, input logic [3:0] tab_ctrl);
    applyStimulus(v, use_tab, tab_ctrl);
    @(negedge clk);
    checkOutput(tag);
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_freeze"},      int'(freeze),      0);
    cmp({tag, "_stall_fetch"}, int'(stall_fetch), 0);
    cmp({tag, "_bubble_ex"},   int'(bubble_ex),   0);
    cmp({tag, "_flush_if_id"}, int'(flush_if_id), 0);
    cmp({tag, "_mem_err"},     int'(mem_err),     0);
    cmp({tag, "_stall_cnt"},   int'(stall_cnt),   0);
    cmp({tag, "_flush_cnt"},   int'(flush_cnt),   0);
  endtask

  task automatic do_reset(input string tag);
    drive(idle_in());
    rst_n = 1'b0;
    #2;
    check_all_zero(tag);
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    in_t v;
    in_t lu;

    // Table: single-cycle decisions from RUN.
    v = idle_in();
    tab[0].in = v; tab[0].ctrl = 4'b0000;
    v = idle_in(); v.fwd = 1; v.exr = 1; v.exw = 1; v.exd = 5; v.s1 = 5; v.u1 = 1;
    tab[1].in = v; tab[1].ctrl = 4'b0110;
    v = idle_in(); v.fwd = 1; v.s1 = 5; v.u1 = 1;
    tab[2].in = v; tab[2].ctrl = 4'b0000;
    v = idle_in(); v.fwd = 1; v.exw = 1; v.exd = 9; v.s2 = 9; v.u2 = 1;
    tab[3].in = v; tab[3].ctrl = 4'b0000;
    v = idle_in(); v.mw = 1; v.md = 7; v.s2 = 7; v.u2 = 1;
    tab[4].in = v; tab[4].ctrl = 4'b0110;
    v = idle_in(); v.mw = 1; v.md = 0; v.s2 = 0; v.u2 = 1;
    tab[5].in = v; tab[5].ctrl = 4'b0000;
    v = idle_in(); v.exw = 1; v.exd = 3; v.s1 = 3; v.u1 = 1;
    tab[6].in = v; tab[6].ctrl = 4'b0110;
    v = idle_in(); v.exw = 1; v.exd = 3; v.s1 = 3; v.u1 = 0;
    tab[7].in = v; tab[7].ctrl = 4'b0000;
    v = idle_in(); v.fwd = 1; v.exr = 1; v.exw = 1; v.exd = 0; v.s1 = 0; v.u1 = 1;
    tab[8].in = v; tab[8].ctrl = 4'b0000;
    v = idle_in(); v.fwd = 1; v.exr = 1; v.exw = 1; v.exd = 12; v.s2 = 12; v.u2 = 1; v.br = 1;
    tab[9].in = v; tab[9].ctrl = 4'b0011;
    v = idle_in(); v.ma = 1; v.rdy = 1;
    tab[10].in = v; tab[10].ctrl = 4'b0000;
    v = idle_in();
    tab[11].in = v; tab[11].ctrl = 4'b0000;

    $display("[TB] start");
    do_reset("reset0");
    for (int i = 0; i < 12; i++) begin
      run_cycle($sformatf("tab%0d", i), tab[i].in, 1'b1, tab[i].ctrl);
    end

    // Load-use with forwarding: exactly one bubble, one stall counted.
    do_reset("reset_lu");
    lu = idle_in(); lu.fwd = 1; lu.exr = 1; lu.exw = 1; lu.exd = 5; lu.s1 = 5; lu.u1 = 1;
    run_cycle("lu_hit", lu, 1'b1, 4'b0110);
    v = idle_in(); v.fwd = 1; v.s1 = 5; v.u1 = 1;
    run_cycle("lu_clear", v, 1'b1, 4'b0000);
    cmp("lu_stall_cnt", int'(stall_cnt), 1);

    // Memory wait with a branch held: freeze 3 cycles, then flush on release.
    do_reset("reset_mw");
    v = idle_in(); v.ma = 1; v.rdy = 0; v.br = 1;
    for (int i = 0; i < 3; i++) run_cycle($sformatf("mw_busy%0d", i), v, 1'b1, 4'b1000);
    v.rdy = 1;
    run_cycle("mw_release", v, 1'b1, 4'b0011);
    cmp("mw_stall_cnt", int'(stall_cnt), 3);
    cmp("mw_flush_cnt", int'(flush_cnt), 1);
    run_cycle("mw_after", idle_in(), 1'b1, 4'b0000);

    // Timeout: ERR after the 4th busy cycle, absorbing, then async reset.
    do_reset("reset_to");
    v = idle_in(); v.ma = 1; v.rdy = 0; v.br = 1;
    for (int i = 0; i < 6; i++) run_cycle($sformatf("to_busy%0d", i), v, 1'b0, 4'b0000);
    cmp("to_mem_err", int'(mem_err), 1);
    run_cycle("to_err_idle", idle_in(), 1'b1, 4'b1000);
    drive(v);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("to_async_rst");
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_cycle("to_after_rst", idle_in(), 1'b1, 4'b0000);

    // Reset mid-wait also drops freeze immediately.
    v = idle_in(); v.ma = 1;
    run_cycle("mw2_busy", v, 1'b1, 4'b1000);
    drive(v);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("mw2_rst_freeze", int'(freeze), 0);
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_cycle("mw2_after_rst", idle_in(), 1'b1, 4'b0000);

    // Saturation: 20 stall cycles with a 4-bit counter.
    do_reset("reset_sat");
    for (int i = 0; i < 20; i++) run_cycle($sformatf("sat%0d", i), lu, 1'b1, 4'b0110);
    cmp("sat_stall_cnt", int'(stall_cnt), 15);
    cmp("sat_flush_cnt", int'(flush_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central pipeline sequencing block for the 5-stage core; sits beside the forwarding unit in the ID/EX boundary logic.
- Decides per cycle whether to freeze all stages (memory wait), flush on taken branch, or stall IF/ID and insert an EX bubble (data hazard).
- Data-hazard rules depend on whether forwarding is enabled.
- Owns a memory-wait timeout FSM and saturating performance counters.

Parameters:
- MEM_TIMEOUT, 64, consecutive not-ready cycles before the error state is entered (>=2).
- CNT_W, 32, width of the performance counters.
- ZERO_REG_HARDWIRED, 1, when 1, register 5'd0 never creates a hazard.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- forward_en  in  1  forwarding unit enabled.
- ID_src1, ID_src2  in  5 each  source registers of the instruction in ID.
- ID_use_src1, ID_use_src2  in  1 each  the matching source is actually read.
- EX_dest  in  5  destination of the instruction in EX.
- EX_regWrite, EX_memRead  in  1 each  EX writes a register / EX is a load.
- MEM_dest  in  5  destination of the instruction in MEM.
- MEM_regWrite  in  1  MEM writes a register.
- MEM_memAccess  in  1  MEM stage has an active memory request.
- mem_ready  in  1  memory completes this cycle.
- branch_taken  in  1  EX resolved a taken branch.
- freeze  out  1  hold every pipeline register and the PC.
- stall_fetch  out  1  hold PC and IF/ID.
- bubble_ex  out  1  load NOP into ID/EX.
- flush_if_id  out  1  clear IF/ID.
- mem_err  out  1  sticky memory-timeout error.
- stall_cnt  out  CNT_W  count of cycles with freeze or stall_fetch.
- flush_cnt  out  CNT_W  count of branch flush events.

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, wait_cnt=0.
  - All 1-bit outputs 0; stall_cnt=0, flush_cnt=0.
  - Outputs return to 0 immediately, mid-wait included.
- Match definition: srcN matches dest when use_srcN=1, srcN==dest, and not (ZERO_REG_HARDWIRED and dest==0).
- Data hazard (haz):
  - forward_en=1: EX_memRead and EX_regWrite and (src1 or src2 matches EX_dest). This is load-use, resolved by exactly one bubble.
  - forward_en=0: (EX_regWrite and match EX_dest) or (MEM_regWrite and match MEM_dest).
- mem_busy = MEM_memAccess and not mem_ready.
- All control outputs are combinational from state and current inputs (zero latency).
- Priority: ERR, then mem_busy, then branch_taken, then haz.
  - state==ERR: freeze=1, others 0.
  - mem_busy: freeze=1, stall_fetch=0, bubble_ex=0, flush_if_id=0. Branch and hazard are deferred, because their sources are held by the freeze.
  - else branch_taken: flush_if_id=1, bubble_ex=1, stall_fetch=0. A hazard in the same cycle is discarded, since the ID instruction is wrong-path.
  - else haz: stall_fetch=1, bubble_ex=1.
  - else: all 0.
- FSM (next-state on rising edge):
  - RUN -> WAIT when mem_busy; wait_cnt<=1.
  - WAIT:
    - mem_busy: wait_cnt increments.
    - When wait_cnt reaches MEM_TIMEOUT-1 with mem_busy still set: -> ERR.
    - not mem_busy: -> RUN, wait_cnt<=0. The release cycle is itself unfrozen.
  - ERR: absorbing until reset. mem_err=1 (registered, asserted from the first ERR cycle).
- Counters:
  - stall_cnt increments on each clock edge where (freeze or stall_fetch) was 1.
  - flush_cnt increments on each edge where flush_if_id was 1.
  - Both saturate at all-ones; no wrap.
- Simultaneous events:
  - mem_ready=1 in the same cycle a request appears: no freeze, no state change.
  - branch_taken during a freeze is honoured on the first unfrozen cycle.

Decomposition:
- Shared package core_pkg:
  - typedef enum logic [1:0] hazard_state_t {RUN, WAIT, ERR}.
  - REG_ADDR_W=5 and ZERO_REG=5'd0 constants, also to be used by the forwarding unit.
- One natural sub-module: sat_counter (parameter W; inputs inc, clk, rst_n; output count). Instantiated twice.

Test Plan:
- Load-use with forward_en=1:
  - Stimulus: EX_memRead=1, EX_regWrite=1, EX_dest=5, ID_src1=5, use_src1=1, for one cycle, then EX cleared.
  - Response: stall_fetch=1 and bubble_ex=1 for exactly 1 cycle; stall_cnt=1.
- forward_en=0 dependency:
  - Stimulus: MEM_regWrite=1, MEM_dest=7, ID_src2=7, use_src2=1; separately repeat with dest=0.
  - Response: stall asserted for dest=7. With dest=0 and ZERO_REG_HARDWIRED=1, no stall.
- Memory wait:
  - Stimulus: MEM_memAccess=1, mem_ready=0 for 3 cycles, with branch_taken=1 held; then mem_ready=1.
  - Response: freeze=1 for 3 cycles. On the release cycle, flush_if_id=1 and bubble_ex=1. stall_cnt=3, flush_cnt=1, state back to RUN.
- Timeout with MEM_TIMEOUT=4:
  - Stimulus: mem_busy held 6 cycles.
  - Response: enter ERR after the 4th busy cycle; mem_err=1, freeze stays 1. Then pulse rst_n=0 mid-ERR: all outputs 0 asynchronously, state=RUN.
- Branch with simultaneous hazard:
  - Stimulus: branch_taken=1 with a load-use match in the same cycle.
  - Response: flush_if_id=1, bubble_ex=1, stall_fetch=0; flush_cnt increments by 1.
- Saturation with CNT_W=4:
  - Stimulus: 20 consecutive stall cycles.
  - Response: stall_cnt reaches 15 and holds.
